// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared FSM encodings, slave address map and decode helper for bus_arbiter
package bus_arbiter_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    // Slave address map (inclusive bounds); anything outside these windows is memory
    localparam logic [31:0] TIM_START  = 32'h1000_0000;
    localparam logic [31:0] TIM_END    = 32'h1000_00FF;
    localparam logic [31:0] UART_START = 32'h1000_0100;
    localparam logic [31:0] UART_END   = 32'h1000_01FF;
    localparam logic [31:0] CRC_START  = 32'h1000_0200;
    localparam logic [31:0] CRC_END    = 32'h1000_02FF;

    // Bit positions inside the one-hot s_sel vector {mem, crc, uart, tim}
    localparam int SEL_TIM  = 0;
    localparam int SEL_UART = 1;
    localparam int SEL_CRC  = 2;
    localparam int SEL_MEM  = 3;

    // Address widths up to 64 bits are compared against the 32-bit map zero-extended
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= {32'b0, lo}) && (addr <= {32'b0, hi});
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/grant bus plus shared slave bus bundle
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Master 0 (core)
    logic              m0_req;
    logic              m0_lock;
    logic              m0_w_en;
    logic              m0_r_en;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;

    // Master 1 (loader/DMA)
    logic              m1_req;
    logic              m1_lock;
    logic              m1_w_en;
    logic              m1_r_en;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;

    // Shared slave bus
    logic              s_w_en;
    logic              s_r_en;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [3:0]        s_sel;
    logic [DATA_W-1:0] s_rdata_tim;
    logic [DATA_W-1:0] s_rdata_uart;
    logic [DATA_W-1:0] s_rdata_crc;
    logic [DATA_W-1:0] s_rdata_mem;

    // Arbiter view: serves both masters and drives the slave bus
    modport slave (
        input  m0_req, m0_lock, m0_w_en, m0_r_en, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_w_en, m1_r_en, m1_addr, m1_wdata,
        input  s_rdata_tim, s_rdata_uart, s_rdata_crc, s_rdata_mem,
        output m0_gnt, m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output s_w_en, s_r_en, s_addr, s_wdata, s_sel
    );

    // Environment view: requesting masters and responding slaves
    modport master (
        output m0_req, m0_lock, m0_w_en, m0_r_en, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_w_en, m1_r_en, m1_addr, m1_wdata,
        output s_rdata_tim, s_rdata_uart, s_rdata_crc, s_rdata_mem,
        input  m0_gnt, m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  s_w_en, s_r_en, s_addr, s_wdata, s_sel
    );

endinterface

// File: rtl/bus_arbiter_addr_decode.sv
// rtl/bus_arbiter_addr_decode.sv - combinational slave select decode from the shared bus address
module addr_decode
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [3:0]        sel
);

    logic [63:0] addr_ext;

    // One-hot select; nothing is selected unless a strobe is active
    always_comb begin
        sel      = 4'b0000;
        addr_ext = 64'(addr);
        if (en) begin
            if (in_range(addr_ext, TIM_START, TIM_END)) begin
                sel[SEL_TIM] = 1'b1;
            end else if (in_range(addr_ext, UART_START, UART_END)) begin
                sel[SEL_UART] = 1'b1;
            end else if (in_range(addr_ext, CRC_START, CRC_END)) begin
                sel[SEL_CRC] = 1'b1;
            end else begin
                sel[SEL_MEM] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with hold limit, lock and read return; optional ARB_ROUND_ROBIN_EN
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

    localparam int                CNT_W     = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [CNT_W-1:0]  hold_cnt;
    logic              hold_expired;
    logic              other_req;
    logic              prefer_m0;

    logic              s_w_en_c;
    logic              s_r_en_c;
    logic [ADDR_W-1:0] s_addr_c;
    logic [DATA_W-1:0] s_wdata_c;
    logic [3:0]        sel_c;
    logic              owner_id;

    logic              rd_pending;
    logic              rd_id;
    logic [3:0]        rd_sel;
    logic [DATA_W-1:0] rdata_mux;
    logic [DATA_W-1:0] m0_rdata_c;
    logic [DATA_W-1:0] m1_rdata_c;
    logic              m0_rvalid_c;
    logic              m1_rvalid_c;

    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign other_req    = ((state_q == ST_OWN0) && bus.m1_req) ||
                          ((state_q == ST_OWN1) && bus.m0_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1;

    // Remember who was granted last; starts as m1 so m0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_m1 <= 1'b1;
        end else if (state_d != state_q) begin
            if (state_d == ST_OWN0) begin
                last_m1 <= 1'b0;
            end else if (state_d == ST_OWN1) begin
                last_m1 <= 1'b1;
            end
        end
    end

    assign prefer_m0 = last_m1;
`else
    assign prefer_m0 = 1'b1;
`endif

    // Ownership state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next owner: idle arbitration, release handoff, and hold-limit preemption
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = prefer_m0 ? ST_OWN0 : ST_OWN1;
                end else if (bus.m0_req) begin
                    state_d = ST_OWN0;
                end else if (bus.m1_req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!bus.m0_req) begin
                    state_d = bus.m1_req ? ST_OWN1 : ST_IDLE;
                end else if (bus.m1_req && hold_expired && !bus.m0_lock) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!bus.m1_req) begin
                    state_d = bus.m0_req ? ST_OWN0 : ST_IDLE;
                end else if (bus.m0_req && hold_expired && !bus.m1_lock) begin
                    state_d = ST_OWN0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Count owner cycles while the other master waits; saturates so a locked owner keeps the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state_d != state_q) begin
            hold_cnt <= '0;
        end else if (other_req) begin
            if (!hold_expired) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end else begin
            hold_cnt <= '0;
        end
    end

    // Slave bus follows the current owner only; non-owner strobes never reach it
    always_comb begin
        s_w_en_c  = 1'b0;
        s_r_en_c  = 1'b0;
        s_addr_c  = '0;
        s_wdata_c = '0;
        owner_id  = 1'b0;
        case (state_q)
            ST_OWN0: begin
                s_w_en_c  = bus.m0_w_en;
                s_r_en_c  = bus.m0_r_en;
                s_addr_c  = bus.m0_addr;
                s_wdata_c = bus.m0_wdata;
                owner_id  = 1'b0;
            end
            ST_OWN1: begin
                s_w_en_c  = bus.m1_w_en;
                s_r_en_c  = bus.m1_r_en;
                s_addr_c  = bus.m1_addr;
                s_wdata_c = bus.m1_wdata;
                owner_id  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_addr_decode (
        .addr (s_addr_c),
        .en   (s_w_en_c | s_r_en_c),
        .sel  (sel_c)
    );

    // Capture issuer and target of each read so the return survives a handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_id      <= 1'b0;
            rd_sel     <= 4'b0000;
        end else begin
            rd_pending <= s_r_en_c;
            if (s_r_en_c) begin
                rd_id  <= owner_id;
                rd_sel <= sel_c;
            end
        end
    end

    // Route the selected slave's data back to the issuing master for one cycle
    always_comb begin
        rdata_mux   = '0;
        m0_rdata_c  = '0;
        m1_rdata_c  = '0;
        m0_rvalid_c = 1'b0;
        m1_rvalid_c = 1'b0;
        case (rd_sel)
            4'b0001: rdata_mux = bus.s_rdata_tim;
            4'b0010: rdata_mux = bus.s_rdata_uart;
            4'b0100: rdata_mux = bus.s_rdata_crc;
            4'b1000: rdata_mux = bus.s_rdata_mem;
            default: rdata_mux = '0;
        endcase
        if (rd_pending) begin
            if (rd_id) begin
                m1_rdata_c  = rdata_mux;
                m1_rvalid_c = 1'b1;
            end else begin
                m0_rdata_c  = rdata_mux;
                m0_rvalid_c = 1'b1;
            end
        end
    end

    assign bus.m0_gnt    = (state_q == ST_OWN0);
    assign bus.m1_gnt    = (state_q == ST_OWN1);
    assign bus.s_w_en    = s_w_en_c;
    assign bus.s_r_en    = s_r_en_c;
    assign bus.s_addr    = s_addr_c;
    assign bus.s_wdata   = s_wdata_c;
    assign bus.s_sel     = sel_c;
    assign bus.m0_rdata  = m0_rdata_c;
    assign bus.m1_rdata  = m1_rdata_c;
    assign bus.m0_rvalid = m0_rvalid_c;
    assign bus.m1_rvalid = m1_rvalid_c;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (HOLD_MAX=4)
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errs   = 0;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .HOLD_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.m0_req = 1'b1; bus.m0_lock = 1'b0; bus.m0_w_en = 1'b1; bus.m0_r_en = 1'b0;
        bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_w_en = 1'b0; bus.m1_r_en = 1'b0;
        bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
        bus.s_rdata_tim  = 32'h7171_0000;
        bus.s_rdata_uart = 32'hA5A5_0001;
        bus.s_rdata_crc  = 32'hC0C0_0002;
        bus.s_rdata_mem  = 32'h1234_5678;

        // Reset held two cycles with m0 requesting
        rst = 1'b1;
        tick();
        tick();
        check("rst_m0_gnt", 64'(bus.m0_gnt), 64'd0);
        check("rst_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        check("rst_s_w_en", 64'(bus.s_w_en), 64'd0);
        check("rst_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
        check("rst_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);
        bus.m0_w_en = 1'b0;
        rst = 1'b0;
        tick();
        check("rel_m0_gnt", 64'(bus.m0_gnt), 64'd1);

        // Release to idle, then simultaneous request after a prior m0 grant
        bus.m0_req = 1'b0;
        tick();
        check("idle_m0_gnt", 64'(bus.m0_gnt), 64'd0);
        bus.m0_req = 1'b1;
        bus.m1_req = 1'b1;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("tie_m1_gnt", 64'(bus.m1_gnt), 64'd1);
`else
        check("tie_m0_gnt", 64'(bus.m0_gnt), 64'd1);
`endif

        // Restart from a clean reset so the preemption sequence is deterministic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        // m0 owns; m1 waits; hold limit 4 cycles
        check("pre_m0_gnt_1", 64'(bus.m0_gnt), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("pre_m0_gnt_%0d", i), 64'(bus.m0_gnt), 64'd1);
        end

        // m0 reads memory on its final owned cycle
        bus.m0_r_en = 1'b1;
        bus.m0_addr = 32'h0000_0040;
        #1;
        check("m0_rd_s_r_en", 64'(bus.s_r_en), 64'd1);
        check("m0_rd_s_sel", 64'(bus.s_sel), 64'h8);
        tick();
        bus.m0_r_en = 1'b0;
        check("hand_m0_gnt", 64'(bus.m0_gnt), 64'd0);
        check("hand_m1_gnt", 64'(bus.m1_gnt), 64'd1);
        check("hand_m0_rvalid", 64'(bus.m0_rvalid), 64'd1);
        check("hand_m0_rdata", 64'(bus.m0_rdata), 64'h1234_5678);
        check("hand_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);

        // m1 back-to-back reads: uart then crc
        bus.m1_r_en = 1'b1;
        bus.m1_addr = 32'h1000_0104;
        #1;
        check("m1_uart_s_sel", 64'(bus.s_sel), 64'h2);
        tick();
        check("m1_uart_rvalid", 64'(bus.m1_rvalid), 64'd1);
        check("m1_uart_rdata", 64'(bus.m1_rdata), 64'hA5A5_0001);
        check("m1_uart_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
        check("m1_uart_m0_rdata", 64'(bus.m0_rdata), 64'd0);
        bus.m1_addr = 32'h1000_0208;
        #1;
        check("m1_crc_s_sel", 64'(bus.s_sel), 64'h4);
        tick();
        bus.m1_r_en = 1'b0;
        check("m1_crc_rvalid", 64'(bus.m1_rvalid), 64'd1);
        check("m1_crc_rdata", 64'(bus.m1_rdata), 64'hC0C0_0002);
        tick();
        check("m1_rvalid_pulse", 64'(bus.m1_rvalid), 64'd0);
        check("m1_still_gnt", 64'(bus.m1_gnt), 64'd1);
        tick();
        check("back_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        check("back_m1_gnt", 64'(bus.m1_gnt), 64'd0);

        // Non-owner write strobe is ignored
        bus.m0_w_en  = 1'b1;
        bus.m0_addr  = 32'h0000_0100;
        bus.m0_wdata = 32'hDEAD_0000;
        bus.m1_w_en  = 1'b1;
        bus.m1_addr  = 32'h1000_0000;
        bus.m1_wdata = 32'hBEEF_1111;
        #1;
        check("own_s_wdata", 64'(bus.s_wdata), 64'hDEAD_0000);
        check("own_s_addr", 64'(bus.s_addr), 64'h0000_0100);
        check("own_s_sel", 64'(bus.s_sel), 64'h8);
        bus.m0_w_en = 1'b0;
        #1;
        check("nonown_s_w_en", 64'(bus.s_w_en), 64'd0);
        check("nonown_s_sel", 64'(bus.s_sel), 64'h0);
        bus.m1_w_en = 1'b0;

        // Locked owner keeps the bus well past the hold limit
        bus.m0_lock = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            check($sformatf("lock_m0_gnt_%0d", i), 64'(bus.m0_gnt), 64'd1);
        end
        bus.m0_lock = 1'b0;
        tick();
        check("unlock_m1_gnt", 64'(bus.m1_gnt), 64'd1);

        // Owner releases with other waiting: direct handoff, then both release to idle
        bus.m1_req = 1'b0;
        tick();
        check("direct_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        check("direct_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        bus.m0_req = 1'b0;
        tick();
        check("final_idle_m0_gnt", 64'(bus.m0_gnt), 64'd0);

        // Reset in the middle of a read discards it
        bus.m0_req = 1'b1;
        tick();
        bus.m0_r_en = 1'b1;
        bus.m0_addr = 32'h0000_0040;
        rst = 1'b1;
        tick();
        check("midrst_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
        check("midrst_m0_rdata", 64'(bus.m0_rdata), 64'd0);
        check("midrst_m0_gnt", 64'(bus.m0_gnt), 64'd0);
        rst = 1'b0;
        bus.m0_r_en = 1'b0;
        tick();
        check("restart_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        check("restart_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
